// File: rtl/muldiv_pkg.sv
// Shared encodings for the CPU32 multiply/divide unit; the control unit
// imports the same op codes when issuing MULT/MULTU/DIV/DIVU.
`timescale 1ns/1ps
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  localparam int MD_ITER = 32;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide producing HI/LO for CPU32.
// Shift-add multiply and restoring divide share one 64-bit accumulator.
`timescale 1ns/1ps
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  md_state_e state, state_nxt;
  logic [5:0] cnt;

  logic               is_div, neg_q, neg_r;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    signed_op, a_neg, b_neg, div_op, div_zero;
  logic [WIDTH-1:0]        a_mag, b_mag;

  assign a_s       = $signed(A);
  assign b_s       = $signed(B);
  assign signed_op = ~op[0];
  assign div_op    = op[1];
  assign a_neg     = signed_op && (a_s < 0);
  assign b_neg     = signed_op && (b_s < 0);
  assign a_mag     = cneg_w(A, a_neg);
  assign b_mag     = cneg_w(B, b_neg);
  assign div_zero  = div_op && (B == '0);

  // Iteration step: multiply adds mcand into the upper half then shifts right;
  // divide shifts left one bit and keeps the trial subtraction if it fits.
  logic [WIDTH:0]     add_sum, rem_sh, rem_sub;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    mul_next = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    rem_sub  = rem_sh - {1'b0, mcand};
    div_next = rem_sub[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                              : {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = cneg_2w(acc, neg_q);
  assign quo_fix  = cneg_w(acc[WIDTH-1:0], neg_q);
  assign rem_fix  = cneg_w(acc[2*WIDTH-1:WIDTH], neg_r);

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start) state_nxt = div_zero ? MD_FIX : MD_CALC;
      MD_CALC: if (cnt == 6'd1) state_nxt = MD_FIX;
      MD_FIX:  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (we_hi) hi <= wdata;
          if (we_lo) lo <= wdata;
          if (start) begin
            busy <= 1'b1;
            dbz  <= div_zero;
            cnt  <= 6'(MD_ITER);
          end
        end
        MD_CALC: cnt <= cnt - 6'd1;
        MD_FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          // A divide-by-zero leaves HI/LO untouched; dbz doubles as that marker.
          if (!dbz) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Operand latch and accumulator; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == MD_IDLE && start) begin
      is_div <= div_op;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      mcand  <= div_op ? b_mag : a_mag;
      acc    <= div_op ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
    end else if (state == MD_CALC) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic
// model of MULT/MULTU/DIV/DIVU, plus directed corner and handshake cases.
`timescale 1ns/1ps
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, we_hi, we_lo;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output bit ez);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ez = o[1] && (b == 32'd0);
    if (ez) return;
    case (o)
      2'b00: begin p = sa * sb;                   m_hi = p[63:32]; m_lo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b};   m_hi = p[63:32]; m_lo = p[31:0]; end
      2'b10: begin q = sa / sb; r = sa % sb;      m_hi = r[31:0];  m_lo = q[31:0]; end
      default: begin m_hi = a % b; m_lo = a / b; end
    endcase
  endtask

  // Issue one op and watch 40 cycles; optionally disturb with start/MTLO mid-CALC.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input string tag);
    bit ez;
    int lat, bcnt, dcnt;
    model(o, a, b, ez);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; op = 2'($urandom);
    lat = -1; bcnt = 0; dcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat < 0) lat = i;
      end
      if (disturb && i == 10) begin
        start = 1'b1; we_lo = 1'b1; wdata = 32'h1234; op = MD_MULTU; A = 32'd3; B = 32'd3;
      end else if (disturb && i == 11) begin
        start = 1'b0; we_lo = 1'b0;
      end
    end
    chk({tag, ".latency"}, 64'(lat), ez ? 64'd2 : 64'd34);
    chk({tag, ".busy_cycles"}, 64'(bcnt), ez ? 64'd1 : 64'd33);
    chk({tag, ".done_pulses"}, 64'(dcnt), 64'd1);
    chk({tag, ".dbz"}, 64'(dbz), 64'(ez));
    chk({tag, ".hi"}, 64'(hi), 64'(m_hi));
    chk({tag, ".lo"}, 64'(lo), 64'(m_lo));
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return 32'($urandom_range(1, 20));
      4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dcnt;
    rst = 1'b1; start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
    op = 2'b00; A = '0; B = '0; wdata = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.dbz",  64'(dbz),  64'd0);
    chk("reset.hi",   64'(hi),   64'd0);
    chk("reset.lo",   64'(lo),   64'd0);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    chk("multu_max.hi_const", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max.lo_const", 64'(lo), 64'h0000_0001);
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg");
    chk("mult_neg.lo_const", 64'(lo), 64'hFFFF_FFEB);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
    chk("div_neg.lo_const", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg.hi_const", 64'(hi), 64'hFFFF_FFFF);
    run_op(MD_DIVU, 32'd100, 32'd0, 1'b0, "divu_zero");
    chk("divu_zero.lo_kept", 64'(lo), 64'hFFFF_FFFD);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_minint");
    chk("div_minint.lo_const", 64'(lo), 64'h8000_0000);
    chk("div_minint.hi_const", 64'(hi), 64'h0);
    run_op(MD_DIVU, 32'd7, 32'd9, 1'b0, "divu_small");
    run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minint");
    run_op(MD_MULT, 32'h0001_2345, 32'hFFFF_0001, 1'b1, "disturbed");

    for (int n = 0; n < 24; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom);
      ra = rand_operand();
      rb = rand_operand();
      run_op(ro, ra, rb, 1'b0, $sformatf("rand%0d_op%0d", n, ro));
    end

    // Abort a multiply with reset partway through CALC.
    @(negedge clk);
    start = 1'b1; op = MD_MULT; A = 32'd12345; B = 32'd678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.hi",   64'(hi),   64'd0);
    chk("abort.lo",   64'(lo),   64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort.no_done", 64'(dcnt), 64'd0);

    we_lo = 1'b1; wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    we_lo = 1'b0;
    chk("mtlo.lo", 64'(lo), 64'h5A5A_5A5A);
    chk("mtlo.hi_kept", 64'(hi), 64'h0);
    we_hi = 1'b1; wdata = 32'hC3C3_0F0F;
    @(negedge clk);
    we_hi = 1'b0;
    chk("mthi.hi", 64'(hi), 64'hC3C3_0F0F);
    chk("mthi.lo_kept", 64'(lo), 64'h5A5A_5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that sits beside the combinational ALU in the CPU32 datapath and produces the HI/LO register pair for MULT, MULTU, DIV and DIVU. It is issued by the control unit over a start/busy/done handshake and takes 33 cycles per operation, since a single-cycle array is not affordable. HI/LO are held here and read by the writeback mux (MFHI/MFLO) or written directly (MTHI/MTLO).

## Interface
- WIDTH, 32, operand and HI/LO width (fixed at 32 for CPU32)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  issue request; sampled only when busy=0
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  in  32  multiplicand / dividend (rs)
- B  in  32  multiplier / divisor (rt)
- we_hi  in  1  MTHI write strobe
- we_lo  in  1  MTLO write strobe
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress; the control unit stalls the PC while busy=1
- done  out  1  one-cycle pulse when HI/LO carry the new result
- dbz  out  1  sticky divide-by-zero flag, cleared by the next accepted start
- hi  out  32  HI register (product[63:32] / remainder)
- lo  out  32  LO register (product[31:0] / quotient)

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 latches op and the operand magnitudes. Signed ops use abs(A) and abs(B) and record the result sign(s); unsigned ops use the operands as given.
  - Clears dbz. Loads the iteration counter with 32. Moves to CALC.
- Divide by zero (DIV/DIVU with B=0) is the exception: go straight to FIX, set dbz=1, leave HI/LO unchanged.
- CALC: one iteration per cycle, counter decrements; moves to FIX when the counter reaches 0.
  - Multiply: radix-2 shift-add on a 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX: apply the sign correction, write HI/LO, pulse done, return to IDLE.
- Sign rules:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
  - MULT/DIV of 0x80000000 use the 33-bit magnitude correctly. DIV 0x80000000 / -1 gives LO=0x80000000, HI=0.
- MTHI/MTLO: in IDLE, we_hi/we_lo write wdata into hi/lo at the clock edge. They are ignored while busy=1.
- start while busy=1 is ignored (no queueing).
- start and we_hi/we_lo in the same IDLE cycle: the start is accepted and the writes also land. The FIX write overwrites them later.

## Timing
- Reset values: busy=0, done=0, dbz=0, hi=0, lo=0, state=IDLE, counter=0.
- Reset has priority over every other input. Reset during CALC/FIX aborts the operation, and no done is produced.
- Accepted start at edge T:
  - busy=1 from T through T+33.
  - hi/lo updated at edge T+33. done=1 and busy=0 in the cycle following T+33.
  - Total latency 33 edges. MTHI/MTLO and a new start can be accepted at T+34.
- Divide by zero: FIX at T+1, dbz=1 and done=1 after edge T+1, busy=0 after T+1.
- done is high for exactly one cycle per accepted start.
- hi/lo are registered outputs and never change except at FIX, MTHI/MTLO, or reset.
- busy is registered; it is not combinationally derived from start.

## Structure
- Shared package (muldiv_pkg):
  - Op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - State encoding MD_IDLE, MD_CALC, MD_FIX.
  - MD_ITER=32.
  - The control unit imports the same op encodings.
- Single module. Multiply and divide share the 64-bit accumulator {hi_w, lo_w}, the counter and the sign logic.
- No sub-module is needed. The datapath is small enough (target roughly 150-250 lines of RTL).

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> done at start+34 cycles, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT A=-3 (0xFFFFFFFD), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV A=-7, B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU A=100, B=0 -> dbz=1, done after 1 cycle, hi/lo keep the previous values; the next start clears dbz.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU A=7, B=9 -> lo=0, hi=7.
- start pulsed again mid-CALC and we_lo=1 with wdata=0x1234 while busy -> both ignored; the original result lands, and only one done pulse occurs.
- rst asserted at cycle 10 of a MULT -> busy=0, done never pulses, hi=lo=0; MTLO of 0x5A5A5A5A in IDLE -> lo=0x5A5A5A5A next cycle.
